cmoms_sched: RTL

- Rate-change scheduler for the C-MOMS spline interpolator datapath.
- Generates the input-tap enable, output/matrix enable and delay-phase index that sequence the IIR prefilter, tap line, spline matrix and d^k LUT.
- Input period R1 and output period R2 are runtime-programmable, replacing the fixed 12-cycle frame.
- Handles priming of the tap line and flags when y_out is valid.

---
 rtl/cmoms_sched_if.sv | 26 ++
 rtl/cmoms_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cmoms_sched_if.sv
// Control and schedule signals for the C-MOMS rate-change scheduler.
// The master drives run/config/stall; the slave (scheduler) drives the enables and status.
interface cmoms_sched_if;
  logic       run;
  logic       cfg_we;
  logic [3:0] cfg_r1;
  logic [3:0] cfg_r2;
  logic       stall;
  logic       ena_in;
  logic       ena_out;
  logic [1:0] phase;
  logic       frame_start;
  logic       y_valid;
  logic       busy;
  logic       cfg_err;

  modport master (
    output run, cfg_we, cfg_r1, cfg_r2, stall,
    input  ena_in, ena_out, phase, frame_start, y_valid, busy, cfg_err
  );

  modport slave (
    input  run, cfg_we, cfg_r1, cfg_r2, stall,
    output ena_in, ena_out, phase, frame_start, y_valid, busy, cfg_err
  );
endinterface

// File: rtl/cmoms_sched.sv
// Rate-change scheduler for the C-MOMS spline interpolator: tap/output enables, delay phase, priming.
// Optional freeze support is compiled in with `define CMOMS_SCHED_STALL_EN.
module cmoms_sched #(
  parameter int IL         = 3,
  parameter int PIPE_DEPTH = 4,
  parameter int R1_DEF     = 3,
  parameter int R2_DEF     = 4
) (
  input  logic         clk,
  input  logic         reset,
  cmoms_sched_if.slave bus
);
  localparam int PW = $clog2(IL + 2);
  localparam int DW = $clog2(PIPE_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t        state_reg;
  logic [3:0]    r1_reg;
  logic [3:0]    r2_reg;
  logic [3:0]    ci_reg;
  logic [3:0]    co_reg;
  logic [PW-1:0] prime_cnt_reg;
  logic [DW-1:0] pipe_cnt_reg;
  logic          in_hit_reg;
  logic          out_hit_reg;
  logic          ena_in_reg;
  logic          ena_out_reg;
  logic          frame_reg;
  logic [1:0]    phase_reg;
  logic          y_valid_reg;
  logic          busy_reg;
  logic          cfg_err_reg;

  logic [3:0]    r1_m1;
  logic [3:0]    r2_m1;
  logic [3:0]    ci_next;
  logic [3:0]    co_next;
  logic          in_hit_next;
  logic          cand_next;
  logic          last_prime;
  logic          cfg_ok;
  logic          hold;
  state_t        adv_state;

`ifdef CMOMS_SCHED_STALL_EN
  assign hold = bus.stall;
`else
  logic unused_stall;
  assign unused_stall = bus.stall;
  assign hold         = 1'b0;
`endif

  // in_hit_reg/out_hit_reg describe the schedule position currently shown; they
  // survive a freeze even though the visible pulses are forced low.
  assign r1_m1       = r1_reg - 4'd1;
  assign r2_m1       = r2_reg - 4'd1;
  assign ci_next     = (ci_reg == r1_m1) ? 4'd0 : ci_reg + 4'd1;
  assign co_next     = (co_reg == r2_m1) ? 4'd0 : co_reg + 4'd1;
  assign in_hit_next = (ci_next == r1_m1);
  assign cand_next   = (co_next == r2_m1);
  assign last_prime  = (state_reg == PRIME) && in_hit_reg && (prime_cnt_reg == PW'(IL));
  assign adv_state   = last_prime ? RUN : state_reg;
  assign cfg_ok      = bus.cfg_we && (state_reg == IDLE) &&
                       (bus.cfg_r1 >= 4'd2) && (bus.cfg_r2 >= 4'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      r1_reg        <= 4'(R1_DEF);
      r2_reg        <= 4'(R2_DEF);
      ci_reg        <= 4'd0;
      co_reg        <= 4'd0;
      prime_cnt_reg <= '0;
      pipe_cnt_reg  <= '0;
      in_hit_reg    <= 1'b0;
      out_hit_reg   <= 1'b0;
      ena_in_reg    <= 1'b0;
      ena_out_reg   <= 1'b0;
      frame_reg     <= 1'b0;
      phase_reg     <= 2'd0;
      y_valid_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      cfg_err_reg <= bus.cfg_we && !cfg_ok;
      if (cfg_ok) begin
        r1_reg <= bus.cfg_r1;
        r2_reg <= bus.cfg_r2;
      end
      case (state_reg)
        IDLE: begin
          if (bus.run) begin
            // Position n=0 can never carry a pulse since both periods are at least 2.
            state_reg     <= PRIME;
            busy_reg      <= 1'b1;
            ci_reg        <= 4'd0;
            co_reg        <= 4'd0;
            prime_cnt_reg <= '0;
            pipe_cnt_reg  <= '0;
            in_hit_reg    <= 1'b0;
            out_hit_reg   <= 1'b0;
            ena_in_reg    <= 1'b0;
            ena_out_reg   <= 1'b0;
            frame_reg     <= 1'b0;
            phase_reg     <= 2'd0;
            y_valid_reg   <= 1'b0;
          end
        end
        default: begin
          if (!bus.run) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            ci_reg        <= 4'd0;
            co_reg        <= 4'd0;
            prime_cnt_reg <= '0;
            pipe_cnt_reg  <= '0;
            in_hit_reg    <= 1'b0;
            out_hit_reg   <= 1'b0;
            ena_in_reg    <= 1'b0;
            ena_out_reg   <= 1'b0;
            frame_reg     <= 1'b0;
            phase_reg     <= 2'd0;
            y_valid_reg   <= 1'b0;
          end else if (hold) begin
            ena_in_reg  <= 1'b0;
            ena_out_reg <= 1'b0;
            frame_reg   <= 1'b0;
          end else begin
            state_reg   <= adv_state;
            ci_reg      <= ci_next;
            co_reg      <= co_next;
            in_hit_reg  <= in_hit_next;
            out_hit_reg <= cand_next && (adv_state == RUN);
            ena_in_reg  <= in_hit_next;
            ena_out_reg <= cand_next && (adv_state == RUN);
            // frame_start marks coincident candidates, gated by neither state nor priming.
            frame_reg   <= in_hit_next && cand_next;
            if ((state_reg == PRIME) && in_hit_reg) begin
              prime_cnt_reg <= prime_cnt_reg + PW'(1);
            end
            if (out_hit_reg) begin
              // For r1 > 4 the compare never matches and the 2-bit phase wraps modulo 4.
              phase_reg <= ({2'b00, phase_reg} == r1_m1) ? 2'd0 : phase_reg + 2'd1;
              if (pipe_cnt_reg != DW'(PIPE_DEPTH)) begin
                pipe_cnt_reg <= pipe_cnt_reg + DW'(1);
              end
              if (pipe_cnt_reg == DW'(PIPE_DEPTH - 1)) begin
                y_valid_reg <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.ena_in      = ena_in_reg;
  assign bus.ena_out     = ena_out_reg;
  assign bus.phase       = phase_reg;
  assign bus.frame_start = frame_reg;
  assign bus.y_valid     = y_valid_reg;
  assign bus.busy        = busy_reg;
  assign bus.cfg_err     = cfg_err_reg;
endmodule
